// File: rtl/read_spi_param.sv
// SPI serial-receive engine: shifts DATA_W bits in from DATA_IN under a divided SCLK
// in any CPOL/CPHA mode, with START/DONE/PERFORM_READ handshake, ABORT and BUSY.
module read_spi_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned HALF_DIV = 1,
    parameter logic        CPOL     = 1'b0,
    parameter logic        CPHA     = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              MSB_FIRST,
    input  logic              ABORT,
    input  logic              DATA_IN,
    output logic              SCLK,
    output logic [DATA_W-1:0] DOUT,
    output logic              DONE,
    output logic              BUSY,
    output logic              PERFORM_READ
);
    localparam int unsigned DIV_W = $clog2(HALF_DIV) + 1;
    localparam int unsigned BIT_W = $clog2(DATA_W) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    localparam logic [4:0] S_IDLE   = 5'b00001;
    localparam logic [4:0] S_SETUP  = 5'b00010;
    localparam logic [4:0] S_PH_A   = 5'b00100;
    localparam logic [4:0] S_PH_B   = 5'b01000;
    localparam logic [4:0] S_FINISH = 5'b10000;

    logic [4:0]        r_state;
    logic [DIV_W-1:0]  r_div;
    logic [BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_msb;
    logic              r_sclk;
    logic [DATA_W-1:0] r_dout;
    logic              r_done;
    logic              r_busy;

    logic [4:0]        w_state_nxt;
    logic [DIV_W-1:0]  w_div_nxt;
    logic [BIT_W-1:0]  w_bit_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_msb_nxt;
    logic              w_sclk_nxt;
    logic [DATA_W-1:0] w_dout_nxt;
    logic              w_done_nxt;
    logic              w_busy_nxt;
    logic              w_sample;
    logic              w_div_end;

    assign w_div_end = (r_div == DIV_LAST);

    // Next-state, sampling and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_msb_nxt   = r_msb;
        w_dout_nxt  = r_dout;
        w_done_nxt  = 1'b0;
        w_sample    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_div_nxt   = '0;
                w_bit_nxt   = '0;
                w_shift_nxt = '0;
                if (START && !ABORT) begin
                    w_state_nxt = S_SETUP;
                    w_msb_nxt   = MSB_FIRST;
                end
            end
            S_SETUP: begin
                if (w_div_end) begin
                    w_div_nxt   = '0;
                    w_state_nxt = S_PH_A;
                    w_sample    = !CPHA;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            S_PH_A: begin
                if (w_div_end) begin
                    w_div_nxt   = '0;
                    w_state_nxt = S_PH_B;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            S_PH_B: begin
                if (w_div_end) begin
                    w_div_nxt = '0;
                    // CPHA=1 samples every PH_B exit; CPHA=0 only when re-entering PH_A
                    w_sample  = CPHA || (r_bit != BIT_LAST);
                    if (r_bit == BIT_LAST) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_bit_nxt   = r_bit + BIT_W'(1);
                        w_state_nxt = S_PH_A;
                    end
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_sample) begin
            w_shift_nxt = r_msb ? {r_shift[DATA_W-2:0], DATA_IN}
                                : {DATA_IN, r_shift[DATA_W-1:1]};
        end

        if (w_state_nxt == S_FINISH) begin
            w_dout_nxt = w_shift_nxt;
            w_done_nxt = 1'b1;
        end

        if (ABORT && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_dout_nxt  = r_dout;
            w_done_nxt  = 1'b0;
        end

        w_sclk_nxt = (w_state_nxt == S_PH_A) ? ~CPOL : CPOL;
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_msb   <= 1'b0;
            r_sclk  <= CPOL;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_msb   <= w_msb_nxt;
            r_sclk  <= w_sclk_nxt;
            r_dout  <= w_dout_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign SCLK         = r_sclk;
    assign DOUT         = r_dout;
    assign DONE         = r_done;
    assign BUSY         = r_busy;
    assign PERFORM_READ = r_busy;

endmodule

// File: tb/tb_read_spi_param.sv
// Scoreboard bench for read_spi_param: four parameter sets run side by side, each with
// its own time-based slave, expected-word queue and per-cycle reference model.
module tb_read_spi_param;
    bit clk = 1'b0;
    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int cfg, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL cfg%0d %s at cycle %0d: got 0x%0h expected 0x%0h", cfg, nm, cyc, act, exp);
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int   DW  = (g == 0) ? 8 : (g == 1) ? 16 : (g == 2) ? 5 : 2;
        localparam int   HD  = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 2 : 3;
        localparam logic CP  = (g == 1) || (g == 3);
        localparam logic CH  = (g == 1) || (g == 2);
        localparam int   TXN = HD * (2 * DW + 1);

        logic          rst, start, msb, abort, din;
        logic          sclk, done, busy, pread;
        logic [DW-1:0] dout;

        read_spi_param #(.DATA_W(DW), .HALF_DIV(HD), .CPOL(CP), .CPHA(CH)) u_dut (
            .CLK(clk), .RST(rst), .START(start), .MSB_FIRST(msb), .ABORT(abort),
            .DATA_IN(din), .SCLK(sclk), .DOUT(dout), .DONE(done), .BUSY(busy),
            .PERFORM_READ(pread)
        );

        // Reference model of the current transfer window (edge numbers)
        int            t0 = 0;
        int            t_stop = -1;
        bit            done_f = 1'b0;
        logic [DW-1:0] cur_word = '0;
        bit            cur_msb = 1'b0;
        logic [DW-1:0] m_dout = '0;
        logic [DW-1:0] sb_q[$];
        bit            fin_req = 1'b0;
        bit            fin_l = 1'b0;

        task automatic accept(input int at, input logic [DW-1:0] w, input bit m);
            t0       = at;
            t_stop   = at + TXN;
            done_f   = 1'b1;
            cur_word = w;
            cur_msb  = m;
            sb_q.push_back(w);
        endtask

        task automatic begin_xfer(input logic [DW-1:0] w, input bit m);
            int c;
            c = cyc;
            start = 1'b1;
            msb = m;
            @(posedge clk);
            accept(c + 1, w, m);
            #1 start = 1'b0;
        endtask

        task automatic wait_done();
            while (cyc < t_stop + 1) @(negedge clk);
        endtask

        task automatic xfer(input logic [DW-1:0] w, input bit m);
            begin_xfer(w, m);
            wait_done();
        endtask

        task automatic b2b(input int n);
            int nt;
            logic [DW-1:0] w;
            bit m;
            start = 1'b1;
            nt = cyc + 1;
            for (int i = 0; i < n; i++) begin
                w = DW'($urandom);
                m = 1'($urandom);
                while (cyc < nt - 1) @(negedge clk);
                msb = m;
                @(posedge clk);
                accept(nt, w, m);
                nt = nt + TXN + 2;
            end
            #1 start = 1'b0;
            wait_done();
        endtask

        // Cancels the running transfer with ABORT (kind 0) or RST (kind 1) sampled at T0+7
        task automatic cancel_at7(input int kind);
            begin_xfer(DW'($urandom), 1'($urandom));
            while (cyc < t0 + 6) @(negedge clk);
            if (kind == 0) abort = 1'b1;
            else rst = 1'b1;
            @(posedge clk);
            t_stop = t0 + 6;
            done_f = 1'b0;
            void'(sb_q.pop_back());
            if (kind != 0) m_dout = '0;
            #1;
            abort = 1'b0;
            rst = 1'b0;
            @(negedge clk);
        endtask

        initial begin
            rst = 1'b1; start = 1'b0; msb = 1'b0; abort = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            xfer(DW'(32'hA5), 1'b1);
            xfer(DW'(32'h8D), 1'b0);
            xfer(DW'(32'hB1), 1'b1);
            xfer(DW'(32'h1234), 1'b1);
            // START during a transfer is ignored
            begin_xfer(DW'(32'h3C), 1'b1);
            while (cyc < t0 + 4) @(negedge clk);
            start = 1'b1; msb = 1'b0;
            @(negedge clk);
            start = 1'b0;
            wait_done();
            b2b(3);
            xfer(DW'(32'h5A), 1'b1);
            cancel_at7(0);
            xfer(DW'($urandom), 1'b0);
            // ABORT beats START in IDLE
            start = 1'b1; abort = 1'b1;
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            repeat (2) @(negedge clk);
            xfer(DW'(32'h5A), 1'b0);
            cancel_at7(1);
            xfer(DW'($urandom), 1'b1);
            for (int i = 0; i < 12; i++) begin
                xfer(DW'($urandom), 1'($urandom));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            repeat (4) @(negedge clk);
            fin_req = 1'b1;
        end

        // Slave: presents bit k only in the cycle before its sampling edge, noise elsewhere
        always @(negedge clk) begin : drv
            int first, d, k;
            first = t0 + HD + (CH ? 2 * HD : 0);
            d = cyc + 1 - first;
            k = (d >= 0) ? d / (2 * HD) : 0;
            if (d >= 0 && (d % (2 * HD)) == 0 && k < DW)
                din = cur_msb ? cur_word[DW-1-k] : cur_word[k];
            else
                din = 1'($urandom);
        end

        always @(negedge clk) begin : mon
            bit   b_exp, d_exp;
            logic s_exp;
            int   k;
            b_exp = (cyc >= t0) && (cyc <= t_stop);
            d_exp = b_exp && done_f && (cyc == t_stop);
            k = cyc - t0 - HD;
            s_exp = CP;
            if (b_exp && k >= 0 && k < 2 * HD * DW && ((k / HD) % 2) == 0) s_exp = ~CP;
            chk("busy", g, 32'(busy), 32'(b_exp));
            chk("perform_read", g, 32'(pread), 32'(b_exp));
            chk("done", g, 32'(done), 32'(d_exp));
            chk("sclk", g, 32'(sclk), 32'(s_exp));
            if (done === 1'b1) begin
                chk("sb_nonempty", g, 32'(sb_q.size() > 0), 32'(1));
                if (sb_q.size() > 0) m_dout = sb_q.pop_front();
                chk("dout_done", g, 32'(dout), 32'(m_dout));
            end else begin
                chk("dout_hold", g, 32'(dout), 32'(m_dout));
            end
            if (fin_req && !fin_l) begin
                chk("sb_leftover", g, 32'(sb_q.size()), 32'(0));
                fin_l = 1'b1;
            end
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(g_cfg[0].fin_l && g_cfg[1].fin_l && g_cfg[2].fin_l && g_cfg[3].fin_l) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60000) begin
            $display("FAIL timeout after %0d cycles: got unfinished run expected all configs done", n);
            $fatal(1, "timeout");
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
